inst_prefetch_buffer: RTL and testbench

Instruction prefetch buffer between the shared single-port memory and the IF/ID register. It issues instruction reads to the memory only on cycles the arbiter marks as fetch slots. Returned words are queued with their PC and PC+4, so the pipeline sees a valid/ready instruction stream. Branch/jump redirects flush the queue and any in-flight read. An optional ECALL detector halts fetching.

---
 rtl/inst_prefetch_buffer_pkg.sv | 22 ++
 rtl/inst_prefetch_buffer_sync_fifo.sv | 57 +++++
 rtl/inst_prefetch_buffer.sv | 107 ++++++++++
 tb/tb_inst_prefetch_buffer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared constants and types for the instruction prefetch buffer.
// ECALL halting is enabled by defining PREFETCH_ECALL_HALT_EN.
package inst_prefetch_buffer_pkg;

    localparam logic [6:0]  OPC_SYSTEM    = 7'b1110011;
    // ECALL: opcode SYSTEM, funct3 = 0, bit 20 = 0 (bit 20 set would be EBREAK)
    localparam logic [31:0] ECALL_MASK    = 32'h0010_707F;
    localparam logic [31:0] ECALL_VALUE   = {25'd0, OPC_SYSTEM};
    localparam logic [31:0] NOP           = 32'h0000_0013;
    localparam int unsigned DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } entry_t;

    function automatic logic is_ecall(input logic [31:0] word);
        return (word & ECALL_MASK) == ECALL_VALUE;
    endfunction

endpackage

// File: rtl/inst_prefetch_buffer_sync_fifo.sv
// Synchronous FIFO with flush; same-cycle push and pop allowed.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer: issues reads in arbiter fetch slots, queues {inst, pc, pc+4}.
// Define PREFETCH_ECALL_HALT_EN to stop fetching after an ECALL is pushed.
module inst_prefetch_buffer
    import inst_prefetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_slot,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic        halted
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          issue;
    entry_t        wr_entry;
    entry_t        head;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push      = inflight && !redirect_valid;

    // Reserve a slot for the word still in flight so the queue can never overflow.
    always_comb begin
        occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
        issue     = !rst && fetch_slot && !redirect_valid && !halted
                    && (occupancy < (CW+1)'(DEPTH));
    end

    assign mem_rd_en = issue;
    assign mem_addr  = fetch_pc;

    always_comb begin
        wr_entry.inst = mem_rdata;
        wr_entry.pc   = inflight_pc;
        wr_entry.pc4  = inflight_pc + 32'd4;
    end

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign out_inst = out_valid ? head.inst : '0;
    assign out_pc   = out_valid ? head.pc   : '0;
    assign out_pc4  = out_valid ? head.pc4  : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
        end
    end

`ifdef PREFETCH_ECALL_HALT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   halted <= 1'b0;
        else if (redirect_valid)                   halted <= 1'b0;
        else if (push && is_ecall(mem_rdata))      halted <= 1'b1;
    end
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Randomized and directed checks of inst_prefetch_buffer against a queue-based reference model.
module tb_inst_prefetch_buffer;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_slot;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_ipc;
    bit          m_inflight;
    bit          m_halted;

    logic [31:0] issue_log[$];
    logic [31:0] pop_pc_log[$];
    logic [31:0] pop_inst_log[$];

    inst_prefetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_slot     (fetch_slot),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_pc4        (out_pc4),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // Memory contents: addr+0x100, with an ECALL at offset 0x14 and an EBREAK at 0x24 of every 256 bytes.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a[7:2])
            6'd5:    return 32'h0000_0073;
            6'd9:    return 32'h0010_0073;
            default: return a + 32'h100;
        endcase
    endfunction

    // Single-port memory: data appears the cycle after a read; garbage otherwise.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= word_at(mem_addr);
        else           mem_rdata <= $urandom;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc      = RESET_PC;
        m_ipc      = '0;
        m_inflight = 0;
        m_halted   = 0;
    endtask

    function automatic bit ecall_word(input logic [31:0] w);
        return w[6:0] == 7'b1110011 && w[14:12] == 3'b000 && !w[20];
    endfunction

    // Called at a falling edge: drive inputs, check outputs, advance model, wait one cycle.
    task automatic step(input bit slot, input bit redir, input logic [31:0] rpc, input bit rdy);
        bit   pop;
        bit   iss;
        int   occ;
        ent_t e;
        fetch_slot     = slot;
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        pop = (mq.size() != 0) && rdy;
        occ = mq.size() + int'(m_inflight) - int'(pop);
        iss = slot && !redir && !m_halted && (occ < DEPTH);
        check_eq("mem_rd_en", mem_rd_en, iss);
        check_eq("mem_addr",  mem_addr,  m_fpc);
        check_eq("out_valid", out_valid, mq.size() != 0);
        check_eq("out_inst",  out_inst,  mq.size() != 0 ? mq[0].inst : 32'h0);
        check_eq("out_pc",    out_pc,    mq.size() != 0 ? mq[0].pc   : 32'h0);
        check_eq("out_pc4",   out_pc4,   mq.size() != 0 ? mq[0].pc4  : 32'h0);
        check_eq("halted",    halted,    m_halted);
        if (mem_rd_en) issue_log.push_back(mem_addr);
        if (out_valid && out_ready) begin
            pop_pc_log.push_back(out_pc);
            pop_inst_log.push_back(out_inst);
        end
        if (redir) begin
            mq.delete();
            m_fpc      = {rpc[31:2], 2'b00};
            m_inflight = 0;
            m_halted   = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_inflight) begin
                e.inst = word_at(m_ipc);
                e.pc   = m_ipc;
                e.pc4  = m_ipc + 32'd4;
                mq.push_back(e);
`ifdef PREFETCH_ECALL_HALT_EN
                if (ecall_word(e.inst)) m_halted = 1;
`endif
            end
            m_inflight = iss;
            if (iss) begin
                m_ipc = m_fpc;
                m_fpc = m_fpc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rd_en"}, mem_rd_en, 1'b0);
        check_eq({tag, "_addr"},  mem_addr,  RESET_PC);
        check_eq({tag, "_valid"}, out_valid, 1'b0);
        check_eq({tag, "_inst"},  out_inst,  32'h0);
        check_eq({tag, "_pc"},    out_pc,    32'h0);
        check_eq({tag, "_pc4"},   out_pc4,   32'h0);
        check_eq({tag, "_halt"},  halted,    1'b0);
    endtask

    task automatic clear_logs();
        issue_log.delete();
        pop_pc_log.delete();
        pop_inst_log.delete();
    endtask

    initial begin
        bit found;
        bit injected;
        rst = 1'b1;
        fetch_slot = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");
        rst = 1'b0;

        // Alternating fetch slots, always ready.
        clear_logs();
        for (int i = 0; i < 24; i++) step(i % 2 == 0, 0, 0, 1);
        check_eq("a_pops_ge3", pop_pc_log.size() >= 3, 1'b1);
        if (pop_pc_log.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check_eq("a_pc",   pop_pc_log[i],   32'(i * 4));
                check_eq("a_inst", pop_inst_log[i], 32'h100 + 32'(i * 4));
            end
        end

        // Consumer stalled, fetch slot every cycle: issue stops at DEPTH.
        step(0, 1, 32'h0, 0);
        clear_logs();
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
        check_eq("b_issues", issue_log.size(), DEPTH);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
        check_eq("b_drained", pop_pc_log.size(), DEPTH);
        if (pop_pc_log.size() == DEPTH)
            for (int i = 0; i < DEPTH; i++) check_eq("b_order", pop_pc_log[i], 32'(i * 4));

        // Redirect to an unaligned target while the 0x10 word returns.
        step(0, 1, 32'h10, 1);
        clear_logs();
        step(1, 0, 0, 1);
        step(0, 1, 32'h203, 1);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 1);
        check_eq("c_issues_ge2", issue_log.size() >= 2, 1'b1);
        if (issue_log.size() >= 2) begin
            check_eq("c_issue0", issue_log[0], 32'h10);
            check_eq("c_issue1", issue_log[1], 32'h200);
        end
        check_eq("c_pops_ge1", pop_pc_log.size() >= 1, 1'b1);
        if (pop_pc_log.size() >= 1) check_eq("c_first_pc", pop_pc_log[0], 32'h200);
        found = 0;
        foreach (pop_pc_log[i]) if (pop_pc_log[i] == 32'h10) found = 1;
        check_eq("c_no_stale", found, 1'b0);

        // Random traffic with one mid-run reset while a word is in flight and 3 are queued.
        injected = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!injected && mq.size() == 3 && m_inflight) begin
                injected = 1;
                fetch_slot = 1'b1;
                rst = 1'b1;
                #1;
                check_reset_outputs("mid_rst");
                model_reset();
                @(negedge clk);
                rst = 1'b0;
                clear_logs();
                step(1, 0, 0, 0);
                check_eq("post_rst_issue", issue_log.size() >= 1 ? issue_log[0] : 32'hFFFF_FFFF, RESET_PC);
            end else begin
                step($urandom_range(0, 1) == 1,
                     $urandom_range(0, 31) == 0,
                     $urandom_range(0, 255) << 2 | $urandom_range(0, 3),
                     $urandom_range(0, 9) < 4);
            end
        end
        check_eq("rst_injected", injected, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
